// File: rtl/game_flow_ctrl.sv
// Snake game flow controller: sequences START / PLAY / PAUSE / OVER screens,
// generates the game step enable, core hold reset, latched direction, display
// source select and the matrix frame reload request.
module game_flow_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned STEP_HZ    = 4,
  parameter int unsigned HOLD_STEPS = 8,
  parameter logic [31:0] UP_CODE    = 32'h20DF6A95,
  parameter logic [31:0] DOWN_CODE  = 32'h20DFEA15,
  parameter logic [31:0] LEFT_CODE  = 32'h20DF1AE5,
  parameter logic [31:0] RIGHT_CODE = 32'h20DF9A65,
  parameter logic [31:0] PAUSE_CODE = 32'h20DF22DD
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [31:0] ir_word,
  input  logic        ir_valid,
  input  logic        game_over,
  input  logic        frame_ack,
  output logic        game_step,
  output logic        game_rst,
  output logic [1:0]  dir,
  output logic [1:0]  screen_sel,
  output logic        paused,
  output logic        frame_req
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HW  = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [DW-1:0] DivLast = DW'(DIV - 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_STEPS);

  typedef enum logic [1:0] {StStart, StPlay, StPause, StOver} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      dir_d;
  logic            step_d;
  logic            game_rst_d;
  logic [1:0]      screen_sel_d;
  logic            paused_d;
  logic            frame_req_d;

  logic            cmd_up, cmd_down, cmd_left, cmd_right, cmd_pause;
  logic            cmd_is_dir;
  logic [1:0]      cmd_dir;
  logic            reversal;
  logic            div_wrap;

  // Commands only exist on the ir_valid strobe; a held word never re-triggers.
  assign cmd_up     = ir_valid && (ir_word == UP_CODE);
  assign cmd_down   = ir_valid && (ir_word == DOWN_CODE);
  assign cmd_left   = ir_valid && (ir_word == LEFT_CODE);
  assign cmd_right  = ir_valid && (ir_word == RIGHT_CODE);
  assign cmd_pause  = ir_valid && (ir_word == PAUSE_CODE);
  assign cmd_is_dir = cmd_up || cmd_down || cmd_left || cmd_right;
  assign div_wrap   = (div_q == DivLast);

  // Map a direction command onto the 2-bit direction encoding.
  always_comb begin
    cmd_dir = 2'b00;
    if (cmd_down) begin
      cmd_dir = 2'b01;
    end else if (cmd_left) begin
      cmd_dir = 2'b10;
    end else if (cmd_right) begin
      cmd_dir = 2'b11;
    end
  end

  // Same axis, opposite sense: UP<->DOWN or LEFT<->RIGHT.
  assign reversal = (cmd_dir[1] == dir[1]) && (cmd_dir[0] != dir[0]);

  // Next-state, divider, hold counter and direction update.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hold_d  = hold_q;
    dir_d   = dir;
    step_d  = 1'b0;
    unique case (state_q)
      StStart: begin
        if (cmd_down) begin
          state_d = StPlay;
          div_d   = '0;
          dir_d   = 2'b11;
        end
      end
      StPlay: begin
        // game_over wins over any command seen in the same cycle.
        if (game_over) begin
          state_d = StOver;
          div_d   = '0;
          hold_d  = '0;
        end else begin
          div_d  = div_wrap ? '0 : div_q + 1'b1;
          step_d = div_wrap;
          if (cmd_pause) begin
            state_d = StPause;
          end else if (cmd_is_dir && !reversal) begin
            dir_d = cmd_dir;
          end
        end
      end
      StPause: begin
        // Divider is frozen here so play resumes mid-period.
        if (game_over) begin
          state_d = StOver;
          div_d   = '0;
          hold_d  = '0;
        end else if (cmd_pause) begin
          state_d = StPlay;
        end
      end
      StOver: begin
        // Divider free-runs to time the hold period in whole step periods.
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap && (hold_q != HoldMax)) begin
          hold_d = hold_q + 1'b1;
        end
        if (cmd_up && (hold_q == HoldMax)) begin
          state_d = StStart;
        end
      end
      default: begin
        state_d = StStart;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    game_rst_d   = 1'b1;
    screen_sel_d = 2'b00;
    paused_d     = 1'b0;
    unique case (state_d)
      StStart: begin
        game_rst_d   = 1'b1;
        screen_sel_d = 2'b00;
      end
      StPlay: begin
        game_rst_d   = 1'b0;
        screen_sel_d = 2'b01;
      end
      StPause: begin
        game_rst_d   = 1'b0;
        screen_sel_d = 2'b01;
        paused_d     = 1'b1;
      end
      StOver: begin
        game_rst_d   = 1'b1;
        screen_sel_d = 2'b10;
      end
      default: begin
        game_rst_d   = 1'b1;
        screen_sel_d = 2'b00;
      end
    endcase
    // Events coalesce; an event coincident with frame_ack keeps the request up.
    frame_req_d = (state_d != state_q) || step_d || (frame_req && !frame_ack);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= StStart;
      div_q      <= '0;
      hold_q     <= '0;
      dir        <= 2'b11;
      game_step  <= 1'b0;
      game_rst   <= 1'b1;
      screen_sel <= 2'b00;
      paused     <= 1'b0;
      frame_req  <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      hold_q     <= hold_d;
      dir        <= dir_d;
      game_step  <= step_d;
      game_rst   <= game_rst_d;
      screen_sel <= screen_sel_d;
      paused     <= paused_d;
      frame_req  <= frame_req_d;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a behavioural model predicts the outputs
// after every clock edge; a monitor pops and compares them.
module tb_game_flow_ctrl;

  localparam int DIV  = 10;
  localparam int HOLD = 2;

  localparam logic [31:0] UP_W    = 32'h20DF6A95;
  localparam logic [31:0] DOWN_W  = 32'h20DFEA15;
  localparam logic [31:0] LEFT_W  = 32'h20DF1AE5;
  localparam logic [31:0] RIGHT_W = 32'h20DF9A65;
  localparam logic [31:0] PAUSE_W = 32'h20DF22DD;

  localparam int M_START = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_word;
  logic        ir_valid;
  logic        game_over;
  logic        frame_ack;
  logic        game_step;
  logic        game_rst;
  logic [1:0]  dir;
  logic [1:0]  screen_sel;
  logic        paused;
  logic        frame_req;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .CLK_HZ    (100),
    .STEP_HZ   (10),
    .HOLD_STEPS(2)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .ir_word   (ir_word),
    .ir_valid  (ir_valid),
    .game_over (game_over),
    .frame_ack (frame_ack),
    .game_step (game_step),
    .game_rst  (game_rst),
    .dir       (dir),
    .screen_sel(screen_sel),
    .paused    (paused),
    .frame_req (frame_req)
  );

  typedef struct {
    logic       step;
    logic       rst;
    logic [1:0] dir;
    logic [1:0] sel;
    logic       paused;
    logic       freq;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cycle  = 0;

  // Reference model state.
  int   m_mode     = M_START;
  int   m_play_cnt = 0;  // PLAY cycles since game start (frozen in PAUSE)
  int   m_over_age = 0;  // cycles spent in OVER
  int   m_dir      = 3;
  bit   m_freq     = 1'b1;
  bit   m_step     = 1'b0;

  // 0 none, 1 up, 2 down, 3 left, 4 right, 5 pause
  function automatic int decode(input logic v, input logic [31:0] w);
    if (!v) return 0;
    if (w == UP_W) return 1;
    if (w == DOWN_W) return 2;
    if (w == LEFT_W) return 3;
    if (w == RIGHT_W) return 4;
    if (w == PAUSE_W) return 5;
    return 0;
  endfunction

  task automatic model_update(input logic r, input logic v, input logic [31:0] w,
                              input logic go, input logic ack);
    int   c;
    int   prev;
    int   nd;
    exp_t e;
    c = decode(v, w);
    if (r) begin
      m_mode = M_START;
      m_dir  = 3;
      m_freq = 1'b1;
      m_step = 1'b0;
    end else begin
      prev   = m_mode;
      m_step = 1'b0;
      case (m_mode)
        M_START: begin
          if (c == 2) begin
            m_mode     = M_PLAY;
            m_play_cnt = 0;
            m_dir      = 3;
          end
        end
        M_PLAY: begin
          if (go) begin
            m_mode     = M_OVER;
            m_over_age = 0;
          end else begin
            m_play_cnt++;
            m_step = (m_play_cnt % DIV == 0);
            if (c == 5) begin
              m_mode = M_PAUSE;
            end else if (c >= 1 && c <= 4) begin
              nd = c - 1;
              if (nd != (m_dir ^ 1)) m_dir = nd;
            end
          end
        end
        M_PAUSE: begin
          if (go) begin
            m_mode     = M_OVER;
            m_over_age = 0;
          end else if (c == 5) begin
            m_mode = M_PLAY;
          end
        end
        default: begin
          if (c == 1 && m_over_age >= HOLD * DIV) m_mode = M_START;
          m_over_age++;
        end
      endcase
      m_freq = (m_mode != prev) || m_step || (m_freq && !ack);
    end
    e.step   = m_step;
    e.rst    = (m_mode == M_START) || (m_mode == M_OVER);
    e.dir    = 2'(m_dir);
    e.sel    = (m_mode == M_START) ? 2'b00 : (m_mode == M_OVER) ? 2'b10 : 2'b01;
    e.paused = (m_mode == M_PAUSE);
    e.freq   = m_freq;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, predict the result, advance to the next negedge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] w,
                     input logic go, input logic ack);
    reset     = r;
    ir_valid  = v;
    ir_word   = w;
    game_over = go;
    frame_ack = ack;
    model_update(r, v, w, go, ack);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, ack);
  endtask

  task automatic cmd(input logic [31:0] w);
    cyc(1'b0, 1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0b, expected %0b", name, cycle, act, expv);
    end
  endtask

  // Monitor: every edge the DUT presents a fresh output set; compare it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("game_step",  {1'b0, game_step}, {1'b0, e.step});
        chk("game_rst",   {1'b0, game_rst},  {1'b0, e.rst});
        chk("dir",        dir,               e.dir);
        chk("screen_sel", screen_sel,        e.sel);
        chk("paused",     {1'b0, paused},    {1'b0, e.paused});
        chk("frame_req",  {1'b0, frame_req}, {1'b0, e.freq});
      end
    end
  end

  // Stimulus: directed scenarios followed by random traffic.
  initial begin
    logic [31:0] codes [5];
    logic        r, v, go, ack;
    logic [31:0] w;
    int          k;
    int          guard;
    codes[0] = UP_W;
    codes[1] = DOWN_W;
    codes[2] = LEFT_W;
    codes[3] = RIGHT_W;
    codes[4] = PAUSE_W;

    // Reset, start, steps at 10-cycle spacing.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(2, 1'b1);
    cyc(1'b0, 1'b0, DOWN_W, 1'b0, 1'b0);  // word without strobe is ignored
    cmd(DOWN_W);
    idle(32, 1'b1);

    // Direction rules.
    cmd(LEFT_W);
    idle(2, 1'b1);
    cmd(UP_W);
    idle(2, 1'b1);
    cmd(DOWN_W);
    idle(2, 1'b1);
    cmd(RIGHT_W);
    idle(2, 1'b1);

    // Pause three cycles after a step, hold 50 cycles, resume.
    guard = 0;
    while (!m_step && guard < 40) begin
      idle(1, 1'b1);
      guard++;
    end
    idle(2, 1'b1);
    cmd(PAUSE_W);
    idle(50, 1'b1);
    cmd(PAUSE_W);
    idle(12, 1'b1);

    // game_over beats a same-cycle PAUSE; UP early is dropped, late is taken.
    cyc(1'b0, 1'b1, PAUSE_W, 1'b1, 1'b1);
    idle(4, 1'b1);
    cmd(UP_W);
    idle(19, 1'b1);
    cmd(UP_W);
    idle(3, 1'b1);

    // Withheld ack across steps, then ack coincident with a step.
    cmd(DOWN_W);
    idle(35, 1'b0);
    guard = 0;
    while (((m_play_cnt + 1) % DIV) != 0 && guard < 20) begin
      idle(1, 1'b0);
      guard++;
    end
    idle(1, 1'b1);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Reset from PAUSE with frame_req low.
    cmd(PAUSE_W);
    idle(3, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Random traffic.
    for (int i = 0; i < 6000; i++) begin
      r   = ($urandom_range(0, 1999) == 0);
      v   = ($urandom_range(0, 7) == 0);
      k   = $urandom_range(0, 5);
      w   = (k < 5) ? codes[k] : $urandom();
      go  = ($urandom_range(0, 399) == 0);
      ack = ($urandom_range(0, 3) == 0);
      cyc(r, v, w, go, ack);
    end

    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
